// File: rtl/hazard_stall_ctrl.sv
// Stall controller for the five-stage MIPS pipeline: Tuse/Tnew hazard stalls plus md-unit busy tracking.
// Optional stall-cycle counters are built when HAZARD_STALL_CNT_EN is defined.
module hazard_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_rs_Tuse,
  input  logic [1:0] D_rt_Tuse,
  input  logic [4:0] E_A3,
  input  logic [1:0] E_Tnew,
  input  logic [4:0] M_A3,
  input  logic [1:0] M_Tnew,
  input  logic       D_is_md,
  input  logic       E_md_start,
  input  logic       E_md_is_div,
  output logic       F_PC_en,
  output logic       FD_en,
  output logic       DE_clr,
  output logic       md_busy
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] md_stall_cycles
`endif
);

  localparam int unsigned STAT_W = 32;

  logic [CNT_W-1:0] r_cnt;
  logic             w_stall_rs;
  logic             w_stall_rt;
  logic             w_stall_md;
  logic             w_stall;

  // md busy counter: a new start always reloads, otherwise count down to zero and hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (E_md_start) begin
      r_cnt <= E_md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign md_busy = (r_cnt != '0);

  // A source stalls when a producer ahead of D will not have its result in time; $0 never stalls
  assign w_stall_rs = (D_rs != 5'd0) &&
                      (((D_rs == E_A3) && (E_Tnew > D_rs_Tuse)) ||
                       ((D_rs == M_A3) && (M_Tnew > D_rs_Tuse)));
  assign w_stall_rt = (D_rt != 5'd0) &&
                      (((D_rt == E_A3) && (E_Tnew > D_rt_Tuse)) ||
                       ((D_rt == M_A3) && (M_Tnew > D_rt_Tuse)));
  assign w_stall_md = D_is_md && (E_md_start || md_busy);
  assign w_stall    = w_stall_rs || w_stall_rt || w_stall_md;

  assign F_PC_en = ~w_stall;
  assign FD_en   = ~w_stall;
  assign DE_clr  = w_stall;

`ifdef HAZARD_STALL_CNT_EN
  logic [STAT_W-1:0] r_stall_cycles;
  logic [STAT_W-1:0] r_md_stall_cycles;

  // Free-running performance counters, wrap naturally at 2^32
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles    <= '0;
      r_md_stall_cycles <= '0;
    end else begin
      if (w_stall)    r_stall_cycles    <= r_stall_cycles + STAT_W'(1);
      if (w_stall_md) r_md_stall_cycles <= r_md_stall_cycles + STAT_W'(1);
    end
  end

  assign stall_cycles    = r_stall_cycles;
  assign md_stall_cycles = r_md_stall_cycles;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl; define HAZARD_STALL_CNT_EN to also check the stall counters.
module tb_hazard_stall_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] D_rs;
  logic [4:0] D_rt;
  logic [1:0] D_rs_Tuse;
  logic [1:0] D_rt_Tuse;
  logic [4:0] E_A3;
  logic [1:0] E_Tnew;
  logic [4:0] M_A3;
  logic [1:0] M_Tnew;
  logic       D_is_md;
  logic       E_md_start;
  logic       E_md_is_div;
  logic       F_PC_en;
  logic       FD_en;
  logic       DE_clr;
  logic       md_busy;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] md_stall_cycles;
`endif

  typedef struct {
    string tag;
    bit    stall;
    bit    busy;
    bit    md;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks;
  int unsigned n_fail;
  int unsigned exp_stall_cnt;
  int unsigned exp_md_cnt;

  hazard_stall_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .D_rs        (D_rs),
    .D_rt        (D_rt),
    .D_rs_Tuse   (D_rs_Tuse),
    .D_rt_Tuse   (D_rt_Tuse),
    .E_A3        (E_A3),
    .E_Tnew      (E_Tnew),
    .M_A3        (M_A3),
    .M_Tnew      (M_Tnew),
    .D_is_md     (D_is_md),
    .E_md_start  (E_md_start),
    .E_md_is_div (E_md_is_div),
    .F_PC_en     (F_PC_en),
    .FD_en       (FD_en),
    .DE_clr      (DE_clr),
    .md_busy     (md_busy)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .md_stall_cycles (md_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input bit stall, input bit busy, input bit md);
    exp_t e;
    e.tag = tag; e.stall = stall; e.busy = busy; e.md = md;
    sb_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare against the live outputs
  task automatic compare_now(output exp_t e);
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
      e.tag = "none"; e.stall = 0; e.busy = 0; e.md = 0;
      return;
    end
    e = sb_q.pop_front();
    check_eq({e.tag, ".F_PC_en"}, 32'(F_PC_en), 32'(!e.stall));
    check_eq({e.tag, ".FD_en"},   32'(FD_en),   32'(!e.stall));
    check_eq({e.tag, ".DE_clr"},  32'(DE_clr),  32'(e.stall));
    check_eq({e.tag, ".md_busy"}, 32'(md_busy), 32'(e.busy));
  endtask

  // One pipeline cycle: compare mid-cycle, then advance past the next rising edge
  task automatic step(input string tag, input bit stall, input bit busy, input bit md);
    exp_t e;
    expect_out(tag, stall, busy, md);
    @(negedge clk);
    compare_now(e);
    @(posedge clk);
    if (reset) begin
      if (e.stall) exp_stall_cnt++;
      if (e.md)    exp_md_cnt++;
    end
    #1;
  endtask

  task automatic idle_inputs();
    D_rs = 5'd0; D_rt = 5'd0; D_rs_Tuse = 2'd3; D_rt_Tuse = 2'd3;
    E_A3 = 5'd0; E_Tnew = 2'd0; M_A3 = 5'd0; M_Tnew = 2'd0;
    D_is_md = 1'b0; E_md_start = 1'b0; E_md_is_div = 1'b0;
  endtask

  initial begin
    exp_t e;
    n_checks = 0; n_fail = 0; exp_stall_cnt = 0; exp_md_cnt = 0;
    reset = 1'b0;
    idle_inputs();

    // Reset held with idle inputs, then released
    for (int i = 0; i < 3; i++) step("reset", 0, 0, 0);
    reset = 1'b1;
    step("post_reset", 0, 0, 0);

    // Four-cycle load-use stall on rs, released when M result is ready
    D_rs = 5'd8; D_rs_Tuse = 2'd0; E_A3 = 5'd8; E_Tnew = 2'd2;
    step("lu_e2", 1, 0, 0);
    E_Tnew = 2'd1;
    step("lu_e1", 1, 0, 0);
    E_A3 = 5'd0; E_Tnew = 2'd0; M_A3 = 5'd8; M_Tnew = 2'd1;
    step("lu_m1a", 1, 0, 0);
    step("lu_m1b", 1, 0, 0);
    M_Tnew = 2'd0;
    step("lu_release", 0, 0, 0);

    // $zero never stalls; Tnew equal to Tuse is on time
    idle_inputs();
    D_rt = 5'd0; D_rt_Tuse = 2'd0; E_A3 = 5'd0; E_Tnew = 2'd2;
    step("zero_rt", 0, 0, 0);
    idle_inputs();
    D_rs = 5'd9; D_rs_Tuse = 2'd1; E_A3 = 5'd9; E_Tnew = 2'd1;
    step("tnew_eq_tuse", 0, 0, 0);
    idle_inputs();

    // mult followed by mflo: stall in the start cycle plus five busy cycles
    E_md_start = 1'b1; E_md_is_div = 1'b0; D_is_md = 1'b1;
    step("mult_start", 1, 0, 1);
    E_md_start = 1'b0;
    for (int i = 0; i < 5; i++) step("mult_busy", 1, 1, 1);
    step("mult_done", 0, 0, 0);
    D_is_md = 1'b0;

`ifdef HAZARD_STALL_CNT_EN
    check_eq("stall_cycles",    stall_cycles,    32'd10);
    check_eq("md_stall_cycles", md_stall_cycles, 32'd6);
    check_eq("stall_track",     stall_cycles,    32'(exp_stall_cnt));
`endif

    // rt hazard against M only, and a dual match where only the E term is late
    D_rt = 5'd5; D_rt_Tuse = 2'd1; M_A3 = 5'd5; M_Tnew = 2'd2;
    step("rt_m_late", 1, 0, 0);
    idle_inputs();
    D_rs = 5'd3; D_rs_Tuse = 2'd1; E_A3 = 5'd3; E_Tnew = 2'd2; M_A3 = 5'd3; M_Tnew = 2'd0;
    step("dual_e_late", 1, 0, 0);
    idle_inputs();

    // md busy without an md consumer in D does not stall
    E_md_start = 1'b1; E_md_is_div = 1'b1;
    step("div_no_use", 0, 0, 0);
    E_md_start = 1'b0;
    for (int i = 0; i < 10; i++) step("div_busy", 0, 1, 0);
    step("div_idle", 0, 0, 0);

    // div restarted by a mult three cycles later: eight busy cycles in total
    E_md_start = 1'b1; E_md_is_div = 1'b1;
    step("rs_div", 0, 0, 0);
    E_md_start = 1'b0;
    step("rs_b1", 0, 1, 0);
    step("rs_b2", 0, 1, 0);
    E_md_start = 1'b1; E_md_is_div = 1'b0;
    step("rs_mult", 0, 1, 0);
    E_md_start = 1'b0;
    for (int i = 0; i < 5; i++) step("rs_tail", 0, 1, 0);
    D_is_md = 1'b1;
    step("rs_done", 0, 0, 0);
    D_is_md = 1'b0;

    // Async reset during a div clears busy within the cycle
    E_md_start = 1'b1; E_md_is_div = 1'b1;
    step("ar_div", 0, 0, 0);
    E_md_start = 1'b0; D_is_md = 1'b1;
    step("ar_b1", 1, 1, 1);
    expect_out("ar_pre", 1, 1, 1);
    compare_now(e);
    reset = 1'b0;
    #1;
    expect_out("ar_async", 0, 0, 0);
    compare_now(e);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step("ar_after", 0, 0, 0);
`ifdef HAZARD_STALL_CNT_EN
    check_eq("stall_cycles_after_rst", stall_cycles, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Stall controller for the five-stage MIPS pipeline.
- Generates the enables for the PC register and the F/D pipeline register, and the clear for the D/E register, from:
  - register-use timing (Tuse/Tnew) of the instructions in D, E and M;
  - a multi-cycle multiply/divide busy counter that it owns.
- Sits beside the D stage; its outputs drive F_PC_en, FD_en and DE_clr directly.

Parameters:
MULT_CYCLES, 5, busy cycles loaded when a mult/multu starts in E
DIV_CYCLES, 10, busy cycles loaded when a div/divu starts in E
CNT_W, 4, busy counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
D_rs  input  5  rs field of instruction in D
D_rt  input  5  rt field of instruction in D
D_rs_Tuse  input  2  cycles until D needs rs (3 = not used)
D_rt_Tuse  input  2  cycles until D needs rt (3 = not used)
E_A3  input  5  destination register of instruction in E (0 = none)
E_Tnew  input  2  cycles until E result is available
M_A3  input  5  destination register of instruction in M (0 = none)
M_Tnew  input  2  cycles until M result is available
D_is_md  input  1  D instruction uses HI/LO or the md unit (mult/div/mfhi/mflo/mthi/mtlo)
E_md_start  input  1  E holds mult/multu/div/divu this cycle
E_md_is_div  input  1  qualifies E_md_start: 1 = div/divu, 0 = mult/multu
F_PC_en  output  1  PC register enable
FD_en  output  1  F/D register enable
DE_clr  output  1  D/E register clear (inserts bubble)
md_busy  output  1  md unit busy (cnt != 0)

Behaviour:
- State: cnt[CNT_W-1:0]. Reset (reset==0, async): cnt=0.
- Each rising edge, reset==1:
  - E_md_start=1: cnt <= E_md_is_div ? DIV_CYCLES : MULT_CYCLES. The load takes priority even if cnt!=0 (restart, latest wins).
  - else if cnt!=0: cnt <= cnt-1.
  - else: hold.
- md_busy = (cnt != 0). It is high for exactly N consecutive cycles after the edge that sampled E_md_start.
- stall_rs = (D_rs!=0) & ((D_rs==E_A3 & E_Tnew>D_rs_Tuse) | (D_rs==M_A3 & M_Tnew>D_rs_Tuse)). stall_rt is identical using rt. All comparisons are unsigned 2-bit.
- stall_md = D_is_md & (E_md_start | md_busy).
- stall = stall_rs | stall_rt | stall_md.
- Outputs are combinational from inputs and cnt; no extra latency:
  - F_PC_en = ~stall
  - FD_en = ~stall
  - DE_clr = stall
- While reset==0: cnt=0, so outputs depend only on the hazard inputs. With idle inputs (all zero, Tuse=3): F_PC_en=1, FD_en=1, DE_clr=0, md_busy=0.
- Register 0 never causes a stall, regardless of A3/Tnew.
- A match against both E_A3 and M_A3 stalls if either term is true. Forwarding priority is not this block's concern.
- Reset asserted mid-count: cnt clears immediately (async). md_busy falls in the same cycle; no residual stall.
- Counter never wraps: decrement is gated by cnt!=0.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- Defined:
  - adds output stall_cycles[31:0], reset to 0;
  - increments on every rising edge where stall=1 and reset==1;
  - wraps 0xFFFFFFFF -> 0;
  - adds output md_stall_cycles[31:0], same rules but counting stall_md=1 only.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 three cycles with idle inputs -> F_PC_en=1, FD_en=1, DE_clr=0, md_busy=0. Release -> unchanged.
- Load-use: D_rs=8, D_rs_Tuse=0, E_A3=8, E_Tnew=2 -> stall=1 (FD_en=0, DE_clr=1). Next cycle M_A3=8, M_Tnew=1, E_A3=0 -> still stalled. Then M_Tnew=0 -> released.
- $zero: D_rt=0, E_A3=0, E_Tnew=2, D_rt_Tuse=0 -> no stall. Also D_rs_Tuse=1, E_Tnew=1 on a match -> no stall.
- Mult then mflo:
  - E_md_start=1, E_md_is_div=0, D_is_md=1 -> stall in that cycle.
  - md_busy=1 for the next 5 cycles, with stall held throughout.
  - Cycle 6 after start: md_busy=0, FD_en=1.
- Div restart: div start, then mult start 3 cycles later -> cnt reloads to 5; md_busy stays high 5 more cycles (8 total). Async reset at cycle 2 of a later div -> md_busy=0 immediately.
- HAZARD_STALL_CNT_EN: 4-cycle load-use stall plus the 6-cycle mflo stall above -> stall_cycles=10, md_stall_cycles=6.
